// File: rtl/data_pack_pkg.sv
// Shared sizing helpers for the data packer and its unpacking counterpart.
// Holds the words-per-packed-word rule and the ceil-log2 counter width.
package data_pack_pkg;

  // Smallest r with 2**r >= v.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Narrow words that make up one packed word.
  function automatic int max_words(input int in_w, input int out_w);
    if (in_w >= out_w) return 1;
    return (out_w + in_w - 1) / in_w;
  endfunction

  // Counter width for 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/packed_output_stage.sv
// Packed output register with its valid flag, drain handshake and the
// wrapping count of packed words handed downstream.
import data_pack_pkg::*;

module packed_output_stage #(
  parameter int OUT_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [OUT_WIDTH-1:0] load_data,
  input  logic                 m_packed_write_ready,
  output logic                 m_packed_write_req,
  output logic [OUT_WIDTH-1:0] m_packed_write_data,
  output logic                 ready,
  output logic [15:0]          packed_count
);

  logic out_valid;

  assign m_packed_write_req = out_valid & m_packed_write_ready;
  // A drain this cycle frees the register for the word completing now.
  assign ready = ~out_valid | m_packed_write_ready;

  // Valid flag: set by a load, cleared by a drain without a reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
    end else if (m_packed_write_req) begin
      out_valid <= 1'b0;
    end
  end

  // Data register only changes on a load, so it holds while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_packed_write_data <= '0;
    end else if (load) begin
      m_packed_write_data <= load_data;
    end
  end

  // Wrapping count of packed words written downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      packed_count <= '0;
    end else if (m_packed_write_req) begin
      packed_count <= packed_count + 16'd1;
    end
  end

endmodule

// File: rtl/data_packer.sv
// Packs narrow words LSB-first into wide words for a downstream FIFO.
// Optional DATA_PACKER_FLUSH_EN lets flush emit a zero-padded partial word.
import data_pack_pkg::*;

module data_packer #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_unpacked_write_req,
  input  logic [IN_WIDTH-1:0]  s_unpacked_write_data,
  output logic                 s_unpacked_write_ready,
  output logic                 m_packed_write_req,
  output logic [OUT_WIDTH-1:0] m_packed_write_data,
  input  logic                 m_packed_write_ready,
  input  logic                 flush,
  output logic [15:0]          packed_count
);

  localparam int MAX_WORDS = max_words(IN_WIDTH, OUT_WIDTH);
  localparam int CNT_W     = cnt_width(MAX_WORDS);
  localparam int ACC_W     = MAX_WORDS * IN_WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WORDS - 1);

  logic [CNT_W-1:0]     cnt;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_merged;
  logic [OUT_WIDTH-1:0] load_data;
  logic                 accept;
  logic                 last_word;
  logic                 flush_hit;
  logic                 load;

  assign accept    = s_unpacked_write_req & s_unpacked_write_ready;
  assign last_word = accept & (cnt == LAST);

`ifdef DATA_PACKER_FLUSH_EN
  assign flush_hit = flush & s_unpacked_write_ready
                   & ((cnt != '0) | accept);
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_hit    = 1'b0;
`endif

  assign load      = last_word | flush_hit;
  // Slots above the current one are zero, giving free padding.
  assign load_data = acc_merged[OUT_WIDTH-1:0];

  // Drop an accepted word into its slot of the accumulator.
  always_comb begin
    acc_merged = acc;
    for (int k = 0; k < MAX_WORDS; k++) begin
      if (accept && (cnt == CNT_W'(k))) begin
        acc_merged[k*IN_WIDTH +: IN_WIDTH] = s_unpacked_write_data;
      end
    end
  end

  // Slot counter: advance per accepted word, restart after a load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Accumulator is wiped on every load so stale slots never leak out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (load) begin
      acc <= '0;
    end else if (accept) begin
      acc <= acc_merged;
    end
  end

  packed_output_stage #(
    .OUT_WIDTH (OUT_WIDTH)
  ) u_out (
    .clk                  (clk),
    .reset                (reset),
    .load                 (load),
    .load_data            (load_data),
    .m_packed_write_ready (m_packed_write_ready),
    .m_packed_write_req   (m_packed_write_req),
    .m_packed_write_data  (m_packed_write_data),
    .ready                (s_unpacked_write_ready),
    .packed_count         (packed_count)
  );

endmodule
